tt_host_bus_bridge: RTL

- Byte-serial host-to-bus bridge behind the Tiny Tapeout pin wrapper; lets the cocotb bench (or an external MCU) read and write core registers and instruction memory through the 8-bit dedicated inputs.
- Synchronises an asynchronous host strobe and assembles command, address and data bytes into single bus transactions.
- Serialises read data back one byte per strobe.
- Parametrised successor to the fixed single-port pin harness: generic address and data width, bus timeout and error reporting.

---
 rtl/tt_host_bus_bridge_pkg.sv | 28 ++
 rtl/tt_host_bus_bridge_if.sv | 23 ++
 rtl/tt_host_bus_bridge_sync_edge.sv | 21 ++
 rtl/tt_host_bus_bridge.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/tt_host_bus_bridge_pkg.sv
// Shared types and helpers for the byte-serial host bus bridge.
// Byte counts are derived from the bus widths.
package tt_host_bus_pkg;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_BUS,
    ST_RDATA
  } state_e;

  localparam int CMD_W_BIT = 7;
  localparam logic [7:0] CMD_RSVD_MASK = 8'h7F;

  function automatic int addr_bytes(input int aw);
    return (aw + 7) / 8;
  endfunction

  function automatic int data_bytes(input int dw);
    return dw / 8;
  endfunction

  function automatic int max_bytes(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tt_host_bus_bridge_if.sv
// Core-side request/acknowledge bus of the host bridge.
// The bridge is the master; the core register file is the slave.
interface tt_host_bus_bridge_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/tt_host_bus_bridge_sync_edge.sv
// Three-flop synchroniser for an async strobe with a
// single-cycle rising-edge pulse taken from the last two stages.
module tt_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);
  logic [2:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], d_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign rise_o = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/tt_host_bus_bridge.sv
// Byte-serial host to core bus bridge: cmd, addr and data bytes
// become one bus transaction; read data is returned byte by byte.
module tt_host_bus_bridge
  import tt_host_bus_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] host_data,
  input  logic       host_stb,
  output logic       busy,
  output logic       rd_valid,
  output logic [7:0] rd_byte,
  output logic       err,
  tt_host_bus_bridge_if.master bus
);
  localparam int AB = addr_bytes(ADDR_W);
  localparam int DB = data_bytes(DATA_W);
  localparam int MB = max_bytes(AB, DB);
  localparam int CW = (MB > 1) ? $clog2(MB) : 1;
  localparam logic [7:0] TMAX = 8'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0]        tmr_q, tmr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              we_q, we_d;
  logic              req_q, req_d;
  logic              err_q, err_d;
  logic              rv_q, rv_d;
  logic              stb;
  logic              last_a, last_d;

  tt_sync_edge u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (host_stb),
    .rise_o (stb)
  );

  assign last_a = (cnt_q == CW'(AB - 1));
  assign last_d = (cnt_q == CW'(DB - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    req_d   = req_q;
    err_d   = err_q;
    rv_d    = rv_q;
    unique case (state_q)
      ST_CMD: begin
        if (stb) begin
          if (|(host_data & CMD_RSVD_MASK)) begin
            err_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            we_d    = host_data[CMD_W_BIT];
            cnt_d   = '0;
            state_d = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (stb) begin
          for (int i = 0; i < ADDR_W; i++)
            if ((i / 8) == int'(cnt_q))
              addr_d[i] = host_data[i % 8];
          if (last_a) begin
            cnt_d   = '0;
            tmr_d   = '0;
            req_d   = ~we_q;
            state_d = we_q ? ST_WDATA : ST_BUS;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_WDATA: begin
        if (stb) begin
          for (int i = 0; i < DATA_W; i++)
            if ((i / 8) == int'(cnt_q))
              wdata_d[i] = host_data[i % 8];
          if (last_d) begin
            cnt_d   = '0;
            tmr_d   = '0;
            req_d   = 1'b1;
            state_d = ST_BUS;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_BUS: begin
        // host strobes seen here are dropped on purpose
        if (bus.bus_ack) begin
          req_d = 1'b0;
          if (we_q) begin
            state_d = ST_CMD;
          end else begin
            rdata_d = bus.bus_rdata;
            rv_d    = 1'b1;
            cnt_d   = '0;
            state_d = ST_RDATA;
          end
        end else if (tmr_q == TMAX) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          rv_d    = 1'b0;
          state_d = ST_CMD;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      ST_RDATA: begin
        if (stb) begin
          if (last_d) begin
            rv_d    = 1'b0;
            rdata_d = '0;
            state_d = ST_CMD;
          end else begin
            rdata_d = rdata_q >> 8;
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_CMD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CMD;
      cnt_q   <= '0;
      tmr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      req_q   <= req_d;
      err_q   <= err_d;
      rv_q    <= rv_d;
    end
  end

  assign busy          = req_q;
  assign rd_valid      = rv_q;
  assign rd_byte       = rdata_q[7:0];
  assign err           = err_q;
  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
endmodule
